// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module      : sram_port_arbiter
// Description : Two-requester round-robin arbiter in front of a single-port
//               SRAM macro, with a power-on clear sweep of the whole array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [MASK_W-1:0] a_wmask,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [MASK_W-1:0] b_wmask,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              init_busy,

    output logic              ram_clk,
    output logic              ram_csb0,
    output logic              ram_web0,
    output logic [MASK_W-1:0] ram_wmask0,
    output logic [ADDR_W-1:0] ram_addr0,
    output logic [DATA_W-1:0] ram_din0,
    input  logic [DATA_W-1:0] ram_dout0,
    output logic              ram_csb1,
    output logic [ADDR_W-1:0] ram_addr1
);

    localparam logic [0:0]        c_INIT      = 1'b0;
    localparam logic [0:0]        c_RUN       = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_last_b;     // 1: B was granted most recently, A wins the next tie
    logic              r_a_rvalid;
    logic              r_b_rvalid;

    logic              w_init;
    logic              w_run;
    logic              w_a_gnt;
    logic              w_b_gnt;

    // Reset gates the combinational outputs so the macro is idle during reset
    // even before the first edge has moved the FSM back to INIT.
    assign w_init  = reset || (r_state == c_INIT);
    assign w_run   = !reset && (r_state == c_RUN);
    assign w_a_gnt = w_run && a_req && (!b_req || r_last_b);
    assign w_b_gnt = w_run && b_req && (!a_req || !r_last_b);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_INIT;
            r_cnt      <= '0;
            r_last_b   <= 1'b1;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_gnt && !a_we;
            r_b_rvalid <= w_b_gnt && !b_we;
            case (r_state)
                c_INIT: begin
                    if (r_cnt == c_LAST_ADDR) begin
                        r_state <= c_RUN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_a_gnt) begin
                        r_last_b <= 1'b0;
                    end else if (w_b_gnt) begin
                        r_last_b <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ram_csb0   = 1'b1;
        ram_web0   = 1'b1;
        ram_wmask0 = '0;
        ram_addr0  = '0;
        ram_din0   = '0;
        if (!reset && (r_state == c_INIT)) begin
            ram_csb0   = 1'b0;
            ram_web0   = 1'b0;
            ram_wmask0 = {MASK_W{1'b1}};
            ram_addr0  = r_cnt;
        end else if (w_a_gnt) begin
            ram_csb0   = 1'b0;
            ram_web0   = !a_we;
            ram_wmask0 = a_wmask;
            ram_addr0  = a_addr;
            ram_din0   = a_wdata;
        end else if (w_b_gnt) begin
            ram_csb0   = 1'b0;
            ram_web0   = !b_we;
            ram_wmask0 = b_wmask;
            ram_addr0  = b_addr;
            ram_din0   = b_wdata;
        end
    end

    assign a_gnt     = w_a_gnt;
    assign b_gnt     = w_b_gnt;
    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    assign a_rdata   = ram_dout0;
    assign b_rdata   = ram_dout0;
    assign init_busy = w_init;

    assign ram_clk   = clock;
    assign ram_csb1  = 1'b1;
    assign ram_addr1 = {ADDR_W{1'b1}};

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, RAM word address width.
REQ-002 SHALL have parameter DATA_W, default 32, RAM data width.
REQ-003 SHALL have parameter MASK_W, default DATA_W/8, byte write-mask width.
REQ-004 SHALL have ports, one per line, as follows (name, direction, width, meaning):
  clock  in  1  single clock; all state on rising edge.
  reset  in  1  synchronous, active-high reset.
  a_req  in  1  port A (cache) access request.
  a_we  in  1  port A write when 1, read when 0.
  a_addr  in  ADDR_W  port A word address.
  a_wmask  in  MASK_W  port A byte write mask.
  a_wdata  in  DATA_W  port A write data.
  a_gnt  out  1  port A request accepted this cycle.
  a_rvalid  out  1  port A read data valid.
  a_rdata  out  DATA_W  port A read data.
  b_req, b_we, b_addr, b_wmask, b_wdata, b_gnt, b_rvalid, b_rdata  same widths/directions as port A, for port B (management/debug).
  init_busy  out  1  power-on clear sweep in progress.
  ram_clk  out  1  macro clock, equal to clock.
  ram_csb0  out  1  port-0 chip select, active low.
  ram_web0  out  1  port-0 write enable, active low.
  ram_wmask0  out  MASK_W  port-0 byte mask.
  ram_addr0  out  ADDR_W  port-0 address.
  ram_din0  out  DATA_W  port-0 write data.
  ram_dout0  in  DATA_W  port-0 read data, valid the cycle after the access edge.
  ram_csb1  out  1  port-1 chip select, tied 1.
  ram_addr1  out  ADDR_W  port-1 address, tied all-ones.

Function
REQ-005 SHALL implement FSM with states INIT and RUN.
REQ-006 INIT SHALL drive one write per cycle: csb0=0, web0=0, wmask0 all ones, din0=0, addr0=sweep counter; counter increments by 1 each cycle.
REQ-007 When counter equals 2^ADDR_W-1 in INIT, that write SHALL complete and state SHALL become RUN next cycle; counter SHALL NOT wrap into a second sweep.
REQ-008 init_busy SHALL be 1 exactly while state is INIT; a_gnt and b_gnt SHALL be 0 in INIT regardless of requests.
REQ-009 In RUN, grant SHALL be combinational in the request cycle: single requester wins; both requesting -> port not granted last time wins (round-robin).
REQ-010 Round-robin pointer SHALL update only on a grant; idle cycles SHALL NOT change it.
REQ-011 In RUN with a grant, ram_csb0=0, ram_web0=~we, ram_addr0/ram_wmask0/ram_din0 SHALL equal the granted port's signals; with no grant ram_csb0=1.
REQ-012 Granted read SHALL assert that port's rvalid for exactly one cycle, the cycle after grant; rdata SHALL equal ram_dout0 in that cycle (latency 1).
REQ-013 Granted write SHALL NOT assert rvalid.
REQ-014 a_rdata and b_rdata SHALL both carry ram_dout0; only rvalid qualifies ownership.
REQ-015 Back-to-back grants SHALL be allowed every cycle; under continuous dual requests grants SHALL alternate A,B,A,B (max wait one cycle).
REQ-016 Requester SHALL hold req and payload stable until gnt; block SHALL NOT buffer requests.
REQ-017 ram_clk SHALL equal clock; ram_csb1=1 and ram_addr1 all ones at all times.

Reset
REQ-018 While reset=1, at each edge: state<=INIT, counter<=0, round-robin pointer<=B (A wins first tie), a_rvalid/b_rvalid<=0.
REQ-019 While reset=1 outputs SHALL be ram_csb0=1, a_gnt=b_gnt=0, init_busy=1.
REQ-020 Reset asserted mid-sweep or mid-RUN SHALL restart the sweep from address 0 and drop any pending rvalid.

Verification
REQ-021 Release reset, no requests -> 512 consecutive writes addr 0..511, din 0, wmask 0xF; init_busy falls cycle 513; then ram_csb0=1.
REQ-022 RUN: A writes 0xDEADBEEF to 0x010, later A reads 0x010 -> a_gnt same cycle, a_rvalid next cycle, a_rdata=0xDEADBEEF, b_rvalid=0.
REQ-023 RUN: A and B request reads continuously for 6 cycles -> grants A,B,A,B,A,B; rvalid each follows by one cycle.
REQ-024 b_req held during INIT at cycle 100 -> b_gnt=0 until first RUN cycle, then b_gnt=1.
REQ-025 Reset pulsed at sweep addr 200 -> next cycle addr0=0, rvalids 0, full 512-cycle sweep repeats.
REQ-026 Byte write wmask 0x2, wdata 0x0000AB00 over 0x11223344 at 0x1FF -> subsequent read returns 0x1122AB44.
